// File: rtl/psum_channel_accum.sv
// psum_channel_accum: accumulates per-input-channel partial sums, then applies bias, ReLU,
// rounding right-shift and unsigned saturation before handing the activation downstream.
module psum_channel_accum #(
    parameter int IN_W   = 29,
    parameter int ACC_W  = 38,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8,
    parameter int CH_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   sum_in,
    input  logic              sum_valid,
    output logic              sum_ready,
    input  logic [CH_W-1:0]   cfg_num_ch,
    input  logic [4:0]        cfg_shift,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  act_out,
    output logic              act_valid,
    input  logic              act_ready
);
    typedef enum logic [1:0] {ACC, POST, OUT} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic [CH_W-1:0]     num_ch_q, num_ch_d;
    logic [4:0]          shift_q, shift_d;
    logic [BIAS_W-1:0]   bias_q, bias_d;
    logic [OUT_W-1:0]    act_q, act_d;
    logic                act_valid_q, act_valid_d;
    logic                fire, first;
    logic [CH_W-1:0]     cfg_eff, num_eff;
    logic [ACC_W:0]      t, r, rnd, q;
    logic [OUT_W-1:0]    sat;

    assign sum_ready = (state_q == ACC);
    assign act_out   = act_q;
    assign act_valid = act_valid_q;

    always_comb begin
        fire    = sum_valid && sum_ready;
        first   = (ch_cnt_q == '0);
        cfg_eff = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
        // On the first sum of a pixel the live config decides whether it is also the last.
        num_eff = first ? cfg_eff : num_ch_q;
        t       = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
        r       = t[ACC_W] ? '0 : t;
        rnd     = (shift_q == 5'd0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (shift_q - 5'd1));
        q       = (r + rnd) >> shift_q;
        sat     = (|q[ACC_W:OUT_W]) ? '1 : q[OUT_W-1:0];
        state_d     = state_q;
        acc_d       = acc_q;
        ch_cnt_d    = ch_cnt_q;
        num_ch_d    = num_ch_q;
        shift_d     = shift_q;
        bias_d      = bias_q;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        case (state_q)
            ACC: begin
                if (fire) begin
                    acc_d    = acc_q + {{(ACC_W-IN_W){sum_in[IN_W-1]}}, sum_in};
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                    if (first) begin
                        num_ch_d = cfg_eff;
                        shift_d  = cfg_shift;
                        bias_d   = bias;
                    end
                    if (ch_cnt_q == num_eff - CH_W'(1)) begin
                        ch_cnt_d = '0;
                        state_d  = POST;
                    end
                end
            end
            POST: begin
                act_d       = sat;
                act_valid_d = 1'b1;
                acc_d       = '0;
                state_d     = OUT;
            end
            OUT: begin
                if (act_ready) begin
                    act_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            ch_cnt_q    <= '0;
            num_ch_q    <= CH_W'(1);
            shift_q     <= '0;
            bias_q      <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            num_ch_q    <= num_ch_d;
            shift_q     <= shift_d;
            bias_q      <= bias_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
        end
    end
endmodule

// File: doc/psum_channel_accum.md
Name: psum_channel_accum

Overview:
- Sits directly downstream of the 9-input adder tree in each convolution lane.
- Consumes one 29-bit signed 3x3-window partial sum per input channel and accumulates cfg_num_ch of them.
- Adds the per-output-channel bias, applies ReLU, then rescales by arithmetic right shift with rounding.
- Saturates to an unsigned 8-bit activation and hands it to the output feature-map writer over a valid/ready handshake.

Parameters:
- IN_W, 29, width of signed partial sum from adder tree
- ACC_W, 38, accumulator width (IN_W + 9, covers 512 channels with no overflow)
- BIAS_W, 16, signed bias width, already in accumulator units
- OUT_W, 8, unsigned activation output width
- CH_W, 10, width of channel-count config

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sum_in  in  IN_W  signed partial sum for the current input channel
- sum_valid  in  1  sum_in valid
- sum_ready  out  1  block can accept sum_in this cycle
- cfg_num_ch  in  CH_W  input channels per output pixel (1..512; 0 treated as 1)
- cfg_shift  in  5  requantisation right-shift amount (0..31)
- bias  in  BIAS_W  signed bias for the current output channel
- act_out  out  OUT_W  final activation
- act_valid  out  1  act_out valid
- act_ready  in  1  consumer accepts act_out

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, acc=0, ch_cnt=0, act_out=0, act_valid=0.
  - sum_ready=1 from the first cycle after rst_n deasserts.
  - Reset mid-operation discards any partial accumulation and any held output.
- FSM states:
  - ACC: sum_ready=1.
  - POST: sum_ready=0.
  - OUT: sum_ready=0, act_valid=1.
- ACC state:
  - Each handshake (sum_valid&sum_ready) adds sign-extended sum_in to acc and increments ch_cnt.
  - On the first handshake of a pixel (ch_cnt==0), cfg_num_ch, cfg_shift and bias are captured into internal registers. They are ignored thereafter until the next pixel.
  - When the handshake occurs with ch_cnt==num_ch_latched-1: acc receives the final sum, ch_cnt clears, next state POST.
  - sum_valid low leaves acc and ch_cnt unchanged. There is no timeout.
- POST state (exactly one cycle):
  - t = acc + sign-extended bias, in ACC_W+1 bits.
  - r = (t<0) ? 0 : t (ReLU).
  - If shift==0: q=r. Otherwise q=(r + (1<<(shift-1))) >> shift (round half up).
  - act_out = (q > 2^OUT_W-1) ? 2^OUT_W-1 : q[OUT_W-1:0].
  - act_out is registered and act_valid=1 at the end of the cycle. Next state OUT.
  - acc clears in the same cycle.
- OUT state:
  - Hold act_out and act_valid stable until act_ready=1.
  - On the handshake cycle, act_valid drops next cycle and state returns to ACC.
  - No bypass: a new pixel's first sum is accepted no earlier than the cycle after the output handshake.
- Latency: the final sum handshake in cycle N gives act_valid=1 in cycle N+2 (registered output).
- Throughput: num_ch+2 cycles per pixel with act_ready held high.
- Widths:
  - All arithmetic before clamping is signed and never overflows for num_ch≤512, |bias|<2^15.
  - The rounding addend is computed in ACC_W+1 bits.
- cfg_num_ch=0 behaves exactly as 1.

Test Plan:
- num_ch=1, bias=0, shift=0, sum_in=100 → act_out=100, act_valid exactly 2 cycles after the handshake.
- num_ch=3, sums 1000, -200, 300, bias=-100, shift=3 → t=1000, (1000+4)>>3=125 → act_out=125.
- ReLU: num_ch=2, sums -500, 100, bias=50 → act_out=0. Saturation: num_ch=512, each sum=+(2^28-1), shift=0 → act_out=255.
- Rounding boundary: t=12, shift=3 → (12+4)>>3=2. t=11 → 1. shift=31, t=2^30 → 1 (round up).
- Backpressure: act_ready held 0 for 5 cycles after act_valid → act_out stable, sum_ready=0 throughout. Release → next pixel accepted the cycle after the handshake.
- Reset mid-pixel: rst_n pulsed low after 2 of 4 channels → act_valid=0. Next 4-channel pixel of all 10s with bias=0, shift=0 → 40, with no leftover partial sum.
